// File: rtl/traffic_ctrl_pkg.sv
// Shared types and constants for the two-road traffic-light sequencer.
// Holds the phase enum, lamp encodings, remaining-time width and a BCD helper.
package traffic_pkg;

  localparam int REMAIN_W = 7;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  typedef enum logic [1:0] {
    S_MG = 2'd0,
    S_MY = 2'd1,
    S_SG = 2'd2,
    S_SY = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_t;

  // Values never exceed 99, so the tens quotient always fits in one BCD digit.
  function automatic bcd_t toBcd(input logic [REMAIN_W-1:0] v);
    bcd_t b;
    b.tens = 4'(v / REMAIN_W'(10));
    b.ones = 4'(v % REMAIN_W'(10));
    return b;
  endfunction

endpackage

// File: rtl/traffic_ctrl_tick_sync.sv
// Two-flop synchroniser with a rising-edge detector for an asynchronous input.
// o_level is the synchronised level; o_tick is a one-cycle pulse per rising edge.
module tick_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_tick
);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_sync3;
  logic [1:0] r_fill;
  logic       r_armed;

  // r_fill marks when r_sync2 holds a genuine post-reset sample; edges are only
  // accepted after the input has been seen low, so a level already high at
  // reset release does not produce a tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_fill  <= 2'b00;
      r_armed <= 1'b0;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_fill  <= {r_fill[0], 1'b1};
      if (r_fill[1] && !r_sync2) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign o_level = r_sync2;
  assign o_tick  = r_sync2 & ~r_sync3 & r_armed;

endmodule

// File: rtl/traffic_ctrl.sv
// Four-phase two-road traffic-light sequencer stepped by ticks from the slow clock.
// Optional pedestrian shortening of the main green is enabled by TRAFFIC_PED_REQ_EN.
module traffic_ctrl
  import traffic_pkg::*;
#(
  parameter int MAIN_GREEN  = 15,
  parameter int MAIN_YELLOW = 3,
  parameter int SIDE_GREEN  = 10,
  parameter int SIDE_YELLOW = 3,
  parameter int PED_T       = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                slow_clk,
  input  logic                ped_req,
  output logic [2:0]          main_rgb,
  output logic [2:0]          side_rgb,
  output logic [REMAIN_W-1:0] remain,
  output logic [3:0]          tens,
  output logic [3:0]          ones
);

  localparam bcd_t RESET_BCD = toBcd(REMAIN_W'(MAIN_GREEN));

  logic                w_tick;
  logic                w_unusedSlowLevel;
  logic                w_pedPend;
  logic                w_shorten;
  state_t              w_nextState;
  logic [REMAIN_W-1:0] w_nextRemain;
  bcd_t                w_nextBcd;

  state_t              r_state;
  logic [REMAIN_W-1:0] r_remain;
  logic [2:0]          r_mainRgb;
  logic [2:0]          r_sideRgb;
  logic [3:0]          r_tens;
  logic [3:0]          r_ones;

  function automatic logic [REMAIN_W-1:0] phaseDur(input state_t s);
    case (s)
      S_MY:    return REMAIN_W'(MAIN_YELLOW);
      S_SG:    return REMAIN_W'(SIDE_GREEN);
      S_SY:    return REMAIN_W'(SIDE_YELLOW);
      default: return REMAIN_W'(MAIN_GREEN);
    endcase
  endfunction

  function automatic logic [2:0] mainLamp(input state_t s);
    case (s)
      S_MG:    return LAMP_GRN;
      S_MY:    return LAMP_YEL;
      default: return LAMP_RED;
    endcase
  endfunction

  function automatic logic [2:0] sideLamp(input state_t s);
    case (s)
      S_SG:    return LAMP_GRN;
      S_SY:    return LAMP_YEL;
      default: return LAMP_RED;
    endcase
  endfunction

  tick_sync u_slowSync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (slow_clk),
    .o_level (w_unusedSlowLevel),
    .o_tick  (w_tick)
  );

`ifdef TRAFFIC_PED_REQ_EN
  logic w_pedLevel;
  logic w_unusedPedTick;
  logic r_pedPend;

  tick_sync u_pedSync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (ped_req),
    .o_level (w_pedLevel),
    .o_tick  (w_unusedPedTick)
  );

  // A request is remembered through main green and yellow and dropped once the
  // side road gets its green.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pedPend <= 1'b0;
    end else if (w_nextState == S_SG && r_state != S_SG) begin
      r_pedPend <= 1'b0;
    end else if (w_pedLevel && (r_state == S_MG || r_state == S_MY)) begin
      r_pedPend <= 1'b1;
    end
  end

  assign w_pedPend = r_pedPend;
`else
  logic w_unusedPed;
  assign w_unusedPed = ped_req;
  assign w_pedPend   = 1'b0;
`endif

  assign w_shorten = w_pedPend && (r_state == S_MG) && (r_remain > REMAIN_W'(PED_T));

  // Any remain of 1 or below ends the phase, so a corrupted zero cannot stall.
  always_comb begin
    w_nextState  = r_state;
    w_nextRemain = r_remain;
    if (w_tick) begin
      if (w_shorten) begin
        w_nextRemain = REMAIN_W'(PED_T);
      end else if (r_remain > REMAIN_W'(1)) begin
        w_nextRemain = r_remain - REMAIN_W'(1);
      end else begin
        case (r_state)
          S_MG:    w_nextState = S_MY;
          S_MY:    w_nextState = S_SG;
          S_SG:    w_nextState = S_SY;
          default: w_nextState = S_MG;
        endcase
        w_nextRemain = phaseDur(w_nextState);
      end
    end
  end

  assign w_nextBcd = toBcd(w_nextRemain);

  // Every output is registered from the same next-state values so lamps,
  // remaining time and digits always change on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_MG;
      r_remain  <= REMAIN_W'(MAIN_GREEN);
      r_mainRgb <= LAMP_GRN;
      r_sideRgb <= LAMP_RED;
      r_tens    <= RESET_BCD.tens;
      r_ones    <= RESET_BCD.ones;
    end else begin
      r_state   <= w_nextState;
      r_remain  <= w_nextRemain;
      r_mainRgb <= mainLamp(w_nextState);
      r_sideRgb <= sideLamp(w_nextState);
      r_tens    <= w_nextBcd.tens;
      r_ones    <= w_nextBcd.ones;
    end
  end

  assign main_rgb = r_mainRgb;
  assign side_rgb = r_sideRgb;
  assign remain   = r_remain;
  assign tens     = r_tens;
  assign ones     = r_ones;

endmodule

// File: tb/tb_traffic_ctrl.sv
// Scoreboard bench for traffic_ctrl: a default-timing DUT and a MAIN_GREEN=1 / SIDE_GREEN=99 DUT.
// Pedestrian expectations follow TRAFFIC_PED_REQ_EN when the bench is built with it.
module tb_traffic_ctrl;

  typedef struct {
    int         cyc;
    logic [2:0] m;
    logic [2:0] s;
    logic [6:0] r;
    logic [3:0] t;
    logic [3:0] o;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic slow_clk = 1'b0;
  logic ped_req = 1'b0;

  logic [2:0] main0, side0, main1, side1;
  logic [6:0] remain0, remain1;
  logic [3:0] tens0, ones0, tens1, ones1;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   monEn = 1'b0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t lastExp[2];
  exp_t lastObs[2];
  bit   primed[2];
  int   mState[2];
  int   mRem[2];
  bit   mPend[2];

  traffic_ctrl u_dut0 (
    .clk(clk), .rst_n(rst_n), .slow_clk(slow_clk), .ped_req(ped_req),
    .main_rgb(main0), .side_rgb(side0), .remain(remain0), .tens(tens0), .ones(ones0)
  );

  traffic_ctrl #(.MAIN_GREEN(1), .MAIN_YELLOW(3), .SIDE_GREEN(99), .SIDE_YELLOW(3), .PED_T(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .slow_clk(slow_clk), .ped_req(ped_req),
    .main_rgb(main1), .side_rgb(side1), .remain(remain1), .tens(tens1), .ones(ones1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int durOf(int d, int st);
    case (st)
      0:       return (d == 0) ? 15 : 1;
      2:       return (d == 0) ? 10 : 99;
      default: return 3;
    endcase
  endfunction

  function automatic int pedOf(int d);
    return (d == 0) ? 5 : 1;
  endfunction

  function automatic exp_t observe(int d);
    exp_t e;
    e.cyc = cyc;
    if (d == 0) begin
      e.m = main0; e.s = side0; e.r = remain0; e.t = tens0; e.o = ones0;
    end else begin
      e.m = main1; e.s = side1; e.r = remain1; e.t = tens1; e.o = ones1;
    end
    return e;
  endfunction

  function automatic bit sameOut(exp_t a, exp_t b);
    return (a.m === b.m) && (a.s === b.s) && (a.r === b.r) && (a.t === b.t) && (a.o === b.o);
  endfunction

  function automatic exp_t modelOut(int d, int c);
    exp_t e;
    e.cyc = c;
    e.m = (mState[d] == 0) ? 3'b001 : (mState[d] == 1) ? 3'b010 : 3'b100;
    e.s = (mState[d] == 2) ? 3'b001 : (mState[d] == 3) ? 3'b010 : 3'b100;
    e.r = 7'(mRem[d]);
    e.t = 4'(mRem[d] / 10);
    e.o = 4'(mRem[d] % 10);
    return e;
  endfunction

  task automatic modelPush(int d, int c);
    exp_t e;
    e = modelOut(d, c);
    if (!sameOut(e, lastExp[d])) begin
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    lastExp[d] = e;
  endtask

  task automatic modelReset(int d, int c, bit push);
    mState[d] = 0;
    mRem[d]   = durOf(d, 0);
    mPend[d]  = 1'b0;
    if (push) modelPush(d, c);
    else      lastExp[d] = modelOut(d, c);
  endtask

  task automatic modelTick(int d, int c);
    if (mState[d] == 0 && mPend[d] && mRem[d] > pedOf(d)) begin
      mRem[d] = pedOf(d);
    end else if (mRem[d] > 1) begin
      mRem[d] = mRem[d] - 1;
    end else begin
      mState[d] = (mState[d] + 1) % 4;
      mRem[d]   = durOf(d, mState[d]);
      if (mState[d] == 2) mPend[d] = 1'b0;
    end
    modelPush(d, c);
  endtask

  // One 16-cycle slow_clk period; the update is due 3 cycles after the sampled rise.
  task automatic slowPulse();
    int k;
    @(posedge clk); #1;
    slow_clk = 1'b1;
    k = cyc;
    modelTick(0, k + 3);
    modelTick(1, k + 3);
    repeat (8) @(posedge clk);
    #1 slow_clk = 1'b0;
    repeat (7) @(posedge clk);
    #2;
  endtask

  task automatic pedPulse();
    @(posedge clk); #1;
    ped_req = 1'b1;
`ifdef TRAFFIC_PED_REQ_EN
    for (int d = 0; d < 2; d++) begin
      if (mState[d] <= 1) mPend[d] = 1'b1;
    end
`endif
    repeat (4) @(posedge clk);
    #1 ped_req = 1'b0;
    repeat (8) @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(int d, string name, logic [2:0] m, logic [2:0] s, int r, int t, int o);
    exp_t a;
    a = observe(d);
    checks++;
    if (a.m !== m || a.s !== s || a.r !== 7'(r) || a.t !== 4'(t) || a.o !== 4'(o)) begin
      errors++;
      $display("[TB] FAIL %s dut%0d: got m=%b s=%b r=%0d t=%0d o=%0d, want m=%b s=%b r=%0d t=%0d o=%0d",
               name, d, a.m, a.s, a.r, a.t, a.o, m, s, r, t, o);
    end
  endtask

  task automatic countPhase(string name, int want);
    logic [2:0] m0, s0;
    int n;
    m0 = main0;
    s0 = side0;
    n = 0;
    do begin
      slowPulse();
      n++;
    end while (main0 === m0 && side0 === s0 && n < 120);
    checks++;
    if (n != want) begin
      errors++;
      $display("[TB] FAIL %s: ticks in phase got %0d, want %0d", name, n, want);
    end
  endtask

  // Every output change is matched against the next queued expectation,
  // including the cycle it was due; any change with nothing queued is an error.
  always @(negedge clk) begin
    if (monEn) begin
      for (int d = 0; d < 2; d++) begin
        exp_t ob;
        exp_t ex;
        ob = observe(d);
        checks++;
        if (!(ob.m === 3'b100 || ob.s === 3'b100) || !$onehot(ob.m) || !$onehot(ob.s)) begin
          errors++;
          $display("[TB] FAIL lamps dut%0d cyc%0d: got main=%b side=%b, want one-hot with a red road",
                   d, cyc, ob.m, ob.s);
        end
        if (!primed[d]) begin
          lastObs[d] = ob;
          primed[d]  = 1'b1;
        end else if (!sameOut(ob, lastObs[d])) begin
          checks++;
          if ((d == 0 ? q0.size() : q1.size()) == 0) begin
            errors++;
            $display("[TB] FAIL unexpected change dut%0d cyc%0d: got m=%b s=%b r=%0d, want no change",
                     d, cyc, ob.m, ob.s, ob.r);
          end else begin
            ex = (d == 0) ? q0.pop_front() : q1.pop_front();
            if (!sameOut(ob, ex) || ex.cyc != cyc) begin
              errors++;
              $display("[TB] FAIL update dut%0d: got cyc=%0d m=%b s=%b r=%0d t=%0d o=%0d, want cyc=%0d m=%b s=%b r=%0d t=%0d o=%0d",
                       d, cyc, ob.m, ob.s, ob.r, ob.t, ob.o, ex.cyc, ex.m, ex.s, ex.r, ex.t, ex.o);
            end
          end
          lastObs[d] = ob;
        end
      end
    end
  end

  task automatic applyStimulus();
    int k;
    bit pedOn;
`ifdef TRAFFIC_PED_REQ_EN
    pedOn = 1'b1;
`else
    pedOn = 1'b0;
`endif
    modelReset(0, 0, 1'b0);
    modelReset(1, 0, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    checkOutput(0, "reset", 3'b001, 3'b100, 15, 1, 5);
    checkOutput(1, "reset", 3'b001, 3'b100, 1, 0, 1);
    monEn = 1'b1;
    repeat (100) @(posedge clk);
    #2;
    checkOutput(0, "idle", 3'b001, 3'b100, 15, 1, 5);

    countPhase("ticksMG", 15);
    countPhase("ticksMY", 3);
    countPhase("ticksSG", 10);
    countPhase("ticksSY", 3);
    checkOutput(0, "wrapMG", 3'b001, 3'b100, 15, 1, 5);

    repeat (3) slowPulse();
    checkOutput(0, "mg12", 3'b001, 3'b100, 12, 1, 2);
    pedPulse();
    slowPulse();
    if (pedOn) checkOutput(0, "pedFirst", 3'b001, 3'b100, 5, 0, 5);
    else       checkOutput(0, "pedFirst", 3'b001, 3'b100, 11, 1, 1);
    pedPulse();
    countPhase("pedRest", pedOn ? 5 : 11);

    repeat (2) slowPulse();
    checkOutput(0, "myLast", 3'b010, 3'b100, 1, 0, 1);
    slowPulse();
    checkOutput(0, "boundary", 3'b100, 3'b001, 10, 1, 0);
    repeat (11) slowPulse();
    checkOutput(0, "sy2", 3'b100, 3'b010, 2, 0, 2);

    @(posedge clk); #1;
    slow_clk = 1'b1;
    rst_n    = 1'b0;
    k = cyc;
    modelReset(0, k + 1, 1'b1);
    modelReset(1, k + 1, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    checkOutput(0, "postRst", 3'b001, 3'b100, 15, 1, 5);
    checkOutput(1, "postRst", 3'b001, 3'b100, 1, 0, 1);
    slow_clk = 1'b0;
    repeat (8) @(posedge clk);
    slowPulse();
    checkOutput(0, "firstTick", 3'b001, 3'b100, 14, 1, 4);
    checkOutput(1, "mg1Tick", 3'b010, 3'b100, 3, 0, 3);
    repeat (3) slowPulse();
    checkOutput(1, "sg99", 3'b100, 3'b001, 99, 9, 9);
    checkOutput(0, "mg11", 3'b001, 3'b100, 11, 1, 1);

    repeat (5) @(posedge clk);
    checks += 2;
    if (q0.size() != 0) begin
      errors++;
      $display("[TB] FAIL pending dut0: got %0d unseen updates, want 0", q0.size());
    end
    if (q1.size() != 0) begin
      errors++;
      $display("[TB] FAIL pending dut1: got %0d unseen updates, want 0", q1.size());
    end
  endtask

  initial begin
    applyStimulus();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion by cycle %0d, want completion", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
